// File: rtl/pad_cfg_pkg.sv
// Shared types, register map and write-sanitising helper for the pad configuration unit.
package pad_cfg_pkg;

   localparam int unsigned ADDR_W = 6;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CFG_W  = 9;

   typedef struct packed {
      logic       irq_en;
      logic       filt_en;
      logic       ie;
      logic       pd;
      logic       pu;
      logic       sl;
      logic       cs;
      logic [1:0] sel;
   } cfg_t;

   localparam logic [ADDR_W-1:0] A_GPIO_OUT = 6'h20;
   localparam logic [ADDR_W-1:0] A_GPIO_OE  = 6'h21;
   localparam logic [ADDR_W-1:0] A_GPIO_IN  = 6'h22;
   localparam logic [ADDR_W-1:0] A_THRESH   = 6'h23;
   localparam logic [ADDR_W-1:0] A_STATUS   = 6'h24;

   // Pads come out of reset as plain inputs: receiver on, driver and pulls off.
   localparam cfg_t CFG_RST = '{irq_en: 1'b0, filt_en: 1'b0, ie: 1'b1, pd: 1'b0,
                                pu: 1'b0, sl: 1'b0, cs: 1'b0, sel: 2'd0};

   // Unsupported alternate selections fall back to GPIO; pull-up wins a pull conflict.
   function automatic cfg_t cfg_sanitize(input logic [CFG_W-1:0] w, input int unsigned num_alt);
      cfg_t c;
      c = cfg_t'(w);
      if (c.sel > 2'(num_alt)) c.sel = 2'd0;
      if (c.pu && c.pd)        c.pd  = 1'b0;
      return c;
   endfunction

endpackage

// File: rtl/pad_cfg_ctrl_if.sv
// Register access bus: single-cycle request, response strobe one cycle later.
interface pad_cfg_ctrl_if;
   import pad_cfg_pkg::*;

   logic              req_valid;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (output req_valid, req_we, req_addr, req_wdata,
                   input  rsp_valid, rsp_rdata, rsp_err);
   modport slave  (input  req_valid, req_we, req_addr, req_wdata,
                   output rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/pad_in_filter.sv
// Per-pad input path: synchroniser, optional glitch filter, and change pulse of the filtered value.
module pad_in_filter #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_W      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              din,
   input  logic              filt_en,
   input  logic [FILT_W-1:0] thresh,
   output logic              dout,
   output logic              chg_c
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync;
   logic                   out_q, out_d;
   logic [FILT_W-1:0]      cnt_q, cnt_d;

   assign sync = sync_q[SYNC_STAGES-1];

   // Counter only runs while filtering, so toggling filt_en always restarts from zero.
   // Committing at cnt>=thresh keeps cnt bounded if thresh drops mid-count.
   always_comb begin
      out_d = out_q;
      cnt_d = cnt_q;
      if (!filt_en) begin
         out_d = sync;
         cnt_d = '0;
      end else if (sync == out_q) begin
         cnt_d = '0;
      end else if (cnt_q >= thresh) begin
         out_d = sync;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + FILT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         out_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         out_q  <= out_d;
         cnt_q  <= cnt_d;
      end
   end

   assign dout  = out_q;
   assign chg_c = out_d ^ out_q;

endmodule

// File: rtl/pad_cfg_ctrl.sv
// Pad configuration register file, GPIO/alternate-function mux, input filtering and edge interrupt.
module pad_cfg_ctrl
   import pad_cfg_pkg::*;
#(
   parameter int unsigned NUM_PADS    = 18,
   parameter int unsigned NUM_ALT     = 2,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILT_W      = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   pad_cfg_ctrl_if.slave                bus,
   input  logic [NUM_PADS*NUM_ALT-1:0]  alt_out,
   input  logic [NUM_PADS*NUM_ALT-1:0]  alt_oe,
   output logic [NUM_PADS-1:0]          pad_in,
   output logic                         irq,
   input  logic [NUM_PADS-1:0]          bidir_in,
   output logic [NUM_PADS-1:0]          bidir_out,
   output logic [NUM_PADS-1:0]          bidir_oe,
   output logic [NUM_PADS-1:0]          bidir_cs,
   output logic [NUM_PADS-1:0]          bidir_sl,
   output logic [NUM_PADS-1:0]          bidir_ie,
   output logic [NUM_PADS-1:0]          bidir_pu,
   output logic [NUM_PADS-1:0]          bidir_pd
);

   cfg_t                cfg_q [NUM_PADS];
   logic [NUM_PADS-1:0] gpio_out_q, gpio_oe_q, status_q;
   logic [NUM_PADS-1:0] chg_c, irq_en, clr_c;
   logic [FILT_W-1:0]   thresh_q;
   logic [DATA_W-1:0]   rd_c;
   logic                err_c, wr_c;
   logic                unused_wdata;

   assign unused_wdata = ^bus.req_wdata;

   // Address decode: read mux and error detection for the current request.
   always_comb begin
      rd_c  = '0;
      err_c = 1'b0;
      case (bus.req_addr)
         A_GPIO_OUT: rd_c = DATA_W'(gpio_out_q);
         A_GPIO_OE:  rd_c = DATA_W'(gpio_oe_q);
         A_GPIO_IN: begin
            rd_c  = DATA_W'(pad_in);
            err_c = bus.req_we;
         end
         A_THRESH:   rd_c = DATA_W'(thresh_q);
         A_STATUS:   rd_c = DATA_W'(status_q);
         default: begin
            err_c = 1'b1;
            for (int p = 0; p < NUM_PADS; p++) begin
               if (bus.req_addr == ADDR_W'(p)) begin
                  rd_c  = DATA_W'(cfg_q[p]);
                  err_c = 1'b0;
               end
            end
         end
      endcase
   end

   assign wr_c  = bus.req_valid & bus.req_we & ~err_c;
   assign clr_c = (wr_c && bus.req_addr == A_STATUS) ? bus.req_wdata[NUM_PADS-1:0] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < NUM_PADS; p++) cfg_q[p] <= CFG_RST;
         gpio_out_q    <= '0;
         gpio_oe_q     <= '0;
         thresh_q      <= '0;
         status_q      <= '0;
         irq           <= 1'b0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_err   <= 1'b0;
         bus.rsp_rdata <= '0;
      end else begin
         bus.rsp_valid <= bus.req_valid;
         bus.rsp_err   <= bus.req_valid & err_c;
         bus.rsp_rdata <= (bus.req_valid && !bus.req_we && !err_c) ? rd_c : '0;
         // A new edge in the same cycle as a W1C keeps its status bit set.
         status_q      <= (status_q & ~clr_c) | chg_c;
         irq           <= |(status_q & irq_en);
         if (wr_c) begin
            case (bus.req_addr)
               A_GPIO_OUT: gpio_out_q <= bus.req_wdata[NUM_PADS-1:0];
               A_GPIO_OE:  gpio_oe_q  <= bus.req_wdata[NUM_PADS-1:0];
               A_THRESH:   thresh_q   <= bus.req_wdata[FILT_W-1:0];
               A_STATUS:   ;
               default: begin
                  for (int p = 0; p < NUM_PADS; p++) begin
                     if (bus.req_addr == ADDR_W'(p))
                        cfg_q[p] <= cfg_sanitize(bus.req_wdata[CFG_W-1:0], NUM_ALT);
                  end
               end
            endcase
         end
      end
   end

   for (genvar p = 0; p < NUM_PADS; p++) begin : g_pad
      logic [3:0] ao, aoe;

      // Widen each pad's alternate slice so a 2-bit select indexes it directly.
      assign ao  = 4'(alt_out[p*NUM_ALT +: NUM_ALT]);
      assign aoe = 4'(alt_oe[p*NUM_ALT +: NUM_ALT]);

      assign bidir_out[p] = (cfg_q[p].sel == 2'd0) ? gpio_out_q[p] : ao[cfg_q[p].sel - 2'd1];
      assign bidir_oe[p]  = (cfg_q[p].sel == 2'd0) ? gpio_oe_q[p]  : aoe[cfg_q[p].sel - 2'd1];
      assign bidir_cs[p]  = cfg_q[p].cs;
      assign bidir_sl[p]  = cfg_q[p].sl;
      assign bidir_ie[p]  = cfg_q[p].ie;
      assign bidir_pu[p]  = cfg_q[p].pu;
      assign bidir_pd[p]  = cfg_q[p].pd;
      assign irq_en[p]    = cfg_q[p].irq_en;

      pad_in_filter #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILT_W      (FILT_W)
      ) u_filt (
         .clk     (clk),
         .rst_n   (rst_n),
         .din     (bidir_in[p] & cfg_q[p].ie),
         .filt_en (cfg_q[p].filt_en),
         .thresh  (thresh_q),
         .dout    (pad_in[p]),
         .chg_c   (chg_c[p])
      );
   end

endmodule
